// File: rtl/stage3_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module  : stage3_hazard_controller_pkg
// Brief   : Shared types and helpers for the stage-3 hazard controller
//           (mul/div sequencer state encoding, register-address compare).
// Revision: 1.0 - initial release
// ============================================================================
package stage3_hazard_controller_pkg;

  // Architectural register address width (x0..x31)
  localparam int c_REG_ADDR_W = 5;

  // Mul/div sequencer states; encodings are fixed so debug dumps stay stable
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_MD_START = 2'd1,
    ST_MD_WAIT  = 2'd2,
    ST_MD_DONE  = 2'd3
  } md_state_t;

  // True when an operand is actually read and names the given register
  function automatic logic src_hit(
    input logic                    i_used,
    input logic [c_REG_ADDR_W-1:0] i_src,
    input logic [c_REG_ADDR_W-1:0] i_dst
  );
    return i_used && (i_src == i_dst);
  endfunction

endpackage
`default_nettype wire

// File: rtl/stage3_hazard_controller_load_use_detector.sv
`default_nettype none
// ============================================================================
// Module  : stage3_hazard_controller_load_use_detector
// Brief   : Combinational load-use compare between the stage-3 load
//           destination and the stage-2 source operands. x0 never hazards.
// Revision: 1.0 - initial release
// ============================================================================
module stage3_hazard_controller_load_use_detector
  import stage3_hazard_controller_pkg::*;
(
  input  logic                    i_ex_mem_read,
  input  logic [c_REG_ADDR_W-1:0] i_ex_addr,
  input  logic [c_REG_ADDR_W-1:0] i_id_addr1,
  input  logic [c_REG_ADDR_W-1:0] i_id_addr2,
  input  logic                    i_id_uses_rs1,
  input  logic                    i_id_uses_rs2,
  output logic                    o_load_use
);

  logic w_dst_valid;
  logic w_rs1_hit;
  logic w_rs2_hit;

  // A load into x0 produces nothing worth waiting for
  assign w_dst_valid = i_ex_mem_read && (i_ex_addr != '0);
  assign w_rs1_hit   = src_hit(i_id_uses_rs1, i_id_addr1, i_ex_addr);
  assign w_rs2_hit   = src_hit(i_id_uses_rs2, i_id_addr2, i_ex_addr);
  assign o_load_use  = w_dst_valid && (w_rs1_hit || w_rs2_hit);

endmodule
`default_nettype wire

// File: rtl/stage3_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : stage3_hazard_controller
// Brief   : Stall/flush sequencer for the RV32IM pipeline. Bubbles on
//           load-use, flushes on a taken stage-3 branch, holds the front end
//           across iterative mul/div ops (START/DONE handshake + watchdog) and
//           keeps a saturating stall-cycle count.
// Revision: 1.0 - initial release
// ============================================================================
module stage3_hazard_controller
  import stage3_hazard_controller_pkg::*;
#(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 32
) (
  input  logic                    i_clk,
  input  logic                    i_reset,
  input  logic [c_REG_ADDR_W-1:0] i_id_addr1,
  input  logic [c_REG_ADDR_W-1:0] i_id_addr2,
  input  logic                    i_id_uses_rs1,
  input  logic                    i_id_uses_rs2,
  input  logic                    i_ex_mem_read,
  input  logic [c_REG_ADDR_W-1:0] i_ex_addr,
  input  logic                    i_ex_muldiv_en,
  input  logic                    i_muldiv_done,
  input  logic                    i_branch_taken,
  output logic                    o_pc_stall,
  output logic                    o_if_id_stall,
  output logic                    o_id_ex_stall,
  output logic                    o_id_ex_bubble,
  output logic                    o_ex_mem_bubble,
  output logic                    o_if_id_flush,
  output logic                    o_muldiv_start,
  output logic                    o_muldiv_busy,
  output logic                    o_md_timeout_err,
  output logic [CNT_W-1:0]        o_stall_count
);

  localparam int                  c_WAIT_W    = $clog2(MD_TIMEOUT);
  localparam logic [c_WAIT_W-1:0] c_WAIT_LAST = c_WAIT_W'(MD_TIMEOUT - 1);

  md_state_t             r_state;
  logic [c_WAIT_W-1:0]   r_wait_cnt;
  logic                  r_start;
  logic                  r_timeout_err;
  logic [CNT_W-1:0]      r_stall_cnt;

  logic                  w_load_use;
  logic                  w_md_hold;

  stage3_hazard_controller_load_use_detector u_load_use (
    .i_ex_mem_read (i_ex_mem_read),
    .i_ex_addr     (i_ex_addr),
    .i_id_addr1    (i_id_addr1),
    .i_id_addr2    (i_id_addr2),
    .i_id_uses_rs1 (i_id_uses_rs1),
    .i_id_uses_rs2 (i_id_uses_rs2),
    .o_load_use    (w_load_use)
  );

  // The hold starts in the same cycle the M-op is first seen in IDLE so the
  // front end never slips past it; MD_DONE releases so the op can retire.
  assign w_md_hold = ((r_state == ST_IDLE) && i_ex_muldiv_en) ||
                     (r_state == ST_MD_START) ||
                     (r_state == ST_MD_WAIT);

  // Mul/div sequencer with watchdog; START is registered so it is exactly
  // the MD_START cycle. A branch coincident with an M-op does not stop it.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_wait_cnt    <= '0;
      r_start       <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_start <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (i_ex_muldiv_en) begin
            r_state <= ST_MD_START;
            r_start <= 1'b1;
          end
        end
        ST_MD_START: begin
          r_state <= i_muldiv_done ? ST_MD_DONE : ST_MD_WAIT;
        end
        ST_MD_WAIT: begin
          if (i_muldiv_done) begin
            r_state <= ST_MD_DONE;
          end else if (r_wait_cnt == c_WAIT_LAST) begin
            r_state       <= ST_MD_DONE;
            r_timeout_err <= 1'b1;
          end else begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
          end
        end
        ST_MD_DONE: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= '0;
        end
        default: begin
          r_state    <= ST_IDLE;
          r_wait_cnt <= '0;
        end
      endcase
    end
  end

  // Priority-encoded pipeline controls: branch flush, then M-op hold, then load-use
  always_comb begin
    o_pc_stall      = 1'b0;
    o_if_id_stall   = 1'b0;
    o_id_ex_stall   = 1'b0;
    o_id_ex_bubble  = 1'b0;
    o_ex_mem_bubble = 1'b0;
    o_if_id_flush   = 1'b0;
    if (i_branch_taken) begin
      o_if_id_flush  = 1'b1;
      o_id_ex_bubble = 1'b1;
    end else if (w_md_hold) begin
      o_pc_stall      = 1'b1;
      o_if_id_stall   = 1'b1;
      o_id_ex_stall   = 1'b1;
      o_ex_mem_bubble = 1'b1;
    end else if (w_load_use) begin
      o_pc_stall     = 1'b1;
      o_if_id_stall  = 1'b1;
      o_id_ex_bubble = 1'b1;
    end
  end

  // Saturating count of PC-stall cycles for performance monitoring
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_stall_cnt <= '0;
    end else if (o_pc_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + 1'b1;
    end
  end

  assign o_muldiv_start   = r_start;
  assign o_muldiv_busy    = (r_state == ST_MD_START) || (r_state == ST_MD_WAIT);
  assign o_md_timeout_err = r_timeout_err;
  assign o_stall_count    = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_stage3_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module  : tb_stage3_hazard_controller
// Brief   : Directed, table-driven bench for stage3_hazard_controller, plus
//           hand-written mul/div, timeout, reset and saturation sequences.
// Revision: 1.0 - initial release
// ============================================================================
module tb_stage3_hazard_controller;

  logic       clk, rst;
  logic [4:0] id_addr1, id_addr2, ex_addr;
  logic       uses1, uses2, ex_rd, md_en, md_done, br;

  logic pc_stall, ifid_stall, idex_stall, idex_bub, exmem_bub, flush, start, busy, err;
  logic [31:0] cnt;
  logic pc_stall2, ifid_stall2, idex_stall2, idex_bub2, exmem_bub2, flush2, start2, busy2, err2;
  logic [3:0]  cnt2;

  logic [7:0] w_out;
  assign w_out = {pc_stall, ifid_stall, idex_stall, idex_bub, exmem_bub, flush, start, busy};

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;
  int start_cyc[$];

  stage3_hazard_controller #(.MD_TIMEOUT(40), .CNT_W(32)) dut (
    .i_clk(clk), .i_reset(rst),
    .i_id_addr1(id_addr1), .i_id_addr2(id_addr2),
    .i_id_uses_rs1(uses1), .i_id_uses_rs2(uses2),
    .i_ex_mem_read(ex_rd), .i_ex_addr(ex_addr),
    .i_ex_muldiv_en(md_en), .i_muldiv_done(md_done), .i_branch_taken(br),
    .o_pc_stall(pc_stall), .o_if_id_stall(ifid_stall), .o_id_ex_stall(idex_stall),
    .o_id_ex_bubble(idex_bub), .o_ex_mem_bubble(exmem_bub), .o_if_id_flush(flush),
    .o_muldiv_start(start), .o_muldiv_busy(busy), .o_md_timeout_err(err),
    .o_stall_count(cnt)
  );

  stage3_hazard_controller #(.MD_TIMEOUT(40), .CNT_W(4)) dut_sat (
    .i_clk(clk), .i_reset(rst),
    .i_id_addr1(id_addr1), .i_id_addr2(id_addr2),
    .i_id_uses_rs1(uses1), .i_id_uses_rs2(uses2),
    .i_ex_mem_read(ex_rd), .i_ex_addr(ex_addr),
    .i_ex_muldiv_en(md_en), .i_muldiv_done(md_done), .i_branch_taken(br),
    .o_pc_stall(pc_stall2), .o_if_id_stall(ifid_stall2), .o_id_ex_stall(idex_stall2),
    .o_id_ex_bubble(idex_bub2), .o_ex_mem_bubble(exmem_bub2), .o_if_id_flush(flush2),
    .o_muldiv_start(start2), .o_muldiv_busy(busy2), .o_md_timeout_err(err2),
    .o_stall_count(cnt2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic       br;
    logic       rd;
    logic [4:0] ex;
    logic [4:0] a1;
    logic [4:0] a2;
    logic       u1;
    logic       u2;
    logic [7:0] exp; // {pc,ifid,idex,idbub,exmembub,flush,start,busy}
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_tot++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, got, exp, $time);
    else n_pass++;
  endtask

  task automatic clear_inputs();
    id_addr1 = '0; id_addr2 = '0; ex_addr = '0;
    uses1 = 0; uses2 = 0; ex_rd = 0; md_en = 0; md_done = 0; br = 0;
  endtask

  // Synchronous-looking reset sequence; returns at posedge+1
  task automatic do_reset();
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outs", {24'd0, w_out}, 32'd0);
    chk("reset_cnt", cnt, 32'd0);
    chk("reset_err", {31'd0, err}, 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    cyc = 0;
  endtask

  // One M-op from IDLE. d = cycles from START to DONE, -1 = DONE never comes.
  // Cycle 0 is IDLE with EX_MULDIV_EN, cycle 1 is START, cycle n_rel is MD_DONE.
  task automatic run_mop(input int d, input logic keep_en);
    int n_rel;
    n_rel = (d < 0) ? (40 + 2) : (d + 2);
    md_en = 1'b1;
    for (int c = 0; c <= n_rel; c++) begin
      md_done = (d >= 0 && c == d + 1);
      @(negedge clk);
      chk($sformatf("md_pc_stall c%0d", c), {31'd0, pc_stall}, {31'd0, (c < n_rel)});
      chk($sformatf("md_exmem_bub c%0d", c), {31'd0, exmem_bub}, {31'd0, (c < n_rel)});
      chk($sformatf("md_start c%0d", c), {31'd0, start}, {31'd0, (c == 1)});
      chk($sformatf("md_busy c%0d", c), {31'd0, busy}, {31'd0, (c >= 1 && c < n_rel)});
      if (start) start_cyc.push_back(cyc);
      @(posedge clk); #1;
      cyc++;
    end
    md_done = 1'b0;
    md_en   = keep_en;
  endtask

  vec_t vecs[10];

  initial begin
    rst = 1'b1;
    clear_inputs();

    //            br rd ex  a1  a2  u1 u2  expected
    vecs[0] = '{0, 1, 5'd5, 5'd5, 5'd7, 1, 1, 8'b1101_0000}; // ld x5 ; add x6,x5,x7
    vecs[1] = '{0, 1, 5'd0, 5'd0, 5'd7, 1, 1, 8'b0000_0000}; // load into x0
    vecs[2] = '{0, 1, 5'd5, 5'd3, 5'd5, 1, 1, 8'b1101_0000}; // rs2 hit
    vecs[3] = '{0, 1, 5'd5, 5'd3, 5'd5, 1, 0, 8'b0000_0000}; // rs2 not used
    vecs[4] = '{0, 0, 5'd5, 5'd5, 5'd7, 1, 1, 8'b0000_0000}; // not a load
    vecs[5] = '{1, 1, 5'd5, 5'd5, 5'd7, 1, 1, 8'b0001_0100}; // branch beats load-use
    vecs[6] = '{1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 8'b0001_0100}; // branch alone
    vecs[7] = '{0, 1, 5'd9, 5'd5, 5'd7, 1, 1, 8'b0000_0000}; // no address match
    vecs[8] = '{0, 1, 5'd5, 5'd5, 5'd2, 0, 1, 8'b0000_0000}; // rs1 hit but unused
    vecs[9] = '{0, 1, 5'd31, 5'd31, 5'd31, 1, 1, 8'b1101_0000}; // x31 both

    // --- Table-driven combinational priority checks (FSM idle) ---
    do_reset();
    for (int i = 0; i < 10; i++) begin
      br = vecs[i].br; ex_rd = vecs[i].rd; ex_addr = vecs[i].ex;
      id_addr1 = vecs[i].a1; id_addr2 = vecs[i].a2;
      uses1 = vecs[i].u1; uses2 = vecs[i].u2;
      @(negedge clk);
      chk($sformatf("vec%0d", i), {24'd0, w_out}, {24'd0, vecs[i].exp});
      @(posedge clk); #1;
    end
    clear_inputs();
    @(negedge clk);
    chk("vec_stall_count", cnt, 32'd3);
    @(posedge clk); #1;

    // --- Single mul, DONE 5 cycles after START: 7 hold cycles ---
    do_reset();
    start_cyc.delete();
    run_mop(5, 1'b0);
    @(negedge clk);
    chk("mul_stall_count", cnt, 32'd7);
    chk("mul_no_err", {31'd0, err}, 32'd0);
    chk("mul_idle_outs", {24'd0, w_out}, 32'd0);
    @(posedge clk); #1;

    // --- Back-to-back div ops: START pulses 8 cycles apart ---
    do_reset();
    start_cyc.delete();
    run_mop(5, 1'b1);
    run_mop(5, 1'b0);
    chk("b2b_start_pulses", start_cyc.size(), 32'd2);
    if (start_cyc.size() == 2) chk("b2b_start_gap", start_cyc[1] - start_cyc[0], 32'd8);
    @(negedge clk);
    chk("b2b_stall_count", cnt, 32'd14);
    @(posedge clk); #1;

    // --- Watchdog: DONE never arrives ---
    do_reset();
    run_mop(-1, 1'b0);
    @(negedge clk);
    chk("to_err_set", {31'd0, err}, 32'd1);
    chk("to_stall_count", cnt, 32'd42);
    chk("to_sat_count", {28'd0, cnt2}, 32'd15);
    @(posedge clk); #1;
    run_mop(2, 1'b0);
    @(negedge clk);
    chk("to_err_sticky", {31'd0, err}, 32'd1);
    @(posedge clk); #1;

    // --- Asynchronous reset in the middle of MD_WAIT ---
    do_reset();
    md_en = 1'b1;
    repeat (3) begin @(posedge clk); #1; end // IDLE -> START -> WAIT -> WAIT
    @(negedge clk);
    chk("pre_rst_busy", {31'd0, busy}, 32'd1);
    #2;
    rst = 1'b1; md_en = 1'b0;
    #1;
    chk("arst_outs", {24'd0, w_out}, 32'd0);
    chk("arst_cnt", cnt, 32'd0);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    start_cyc.delete();
    run_mop(2, 1'b0);
    chk("arst_restart_start", start_cyc.size(), 32'd1);
    @(negedge clk);
    chk("arst_restart_cnt", cnt, 32'd4);
    @(posedge clk); #1;

    // --- Saturation: 20 load-use stall cycles on a 4-bit counter ---
    do_reset();
    ex_rd = 1; ex_addr = 5'd5; id_addr1 = 5'd5; uses1 = 1;
    repeat (20) begin @(posedge clk); #1; end
    clear_inputs();
    @(negedge clk);
    chk("sat_cnt4", {28'd0, cnt2}, 32'd15);
    chk("sat_cnt32", cnt, 32'd20);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
`default_nettype wire
